wbm_spi_ctrl: RTL and testbench

- Wishbone-clock-domain consumer of the byte stream that the SPI receive stage exports over its req/ack/data crossing handshake.
- Synchronises the incoming handshake and parses bytes into read/write commands.
- Runs one Wishbone B4 classic master cycle per command.
- Exports read data, byte by byte, through the same handshake style to the SPI transmit stage.

---
 rtl/wbm_spi_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_wbm_spi_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbm_spi_ctrl.sv
// wbm_spi_ctrl: Wishbone-domain command engine fed by the SPI receive toggle handshake.
// Parses read/write commands, runs one classic Wishbone cycle each and returns read data over the tx handshake.
module wbm_spi_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_handshake_req,
    input  logic [7:0]            rx_handshake_data,
    output logic                  rx_handshake_ack,
    output logic                  tx_handshake_req,
    input  logic                  tx_handshake_ack,
    output logic [7:0]            tx_handshake_data,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [31:0]           wb_dat_o,
    input  logic [31:0]           wb_dat_i,
    input  logic                  wb_ack_i
);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_WB    = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t                state_r, state_s;
    logic                  rx_meta_r, rx_req_r, tx_meta_r, tx_ack_r;
    logic                  rx_ack_r, rx_ack_s;
    logic                  tx_req_r, tx_req_s;
    logic [7:0]            tx_data_r, tx_data_s;
    logic                  cyc_r, cyc_s;
    logic                  we_out_r, we_out_s;
    logic                  cmd_we_r, cmd_we_s;
    logic [ADDR_WIDTH-1:0] adr_r, adr_s;
    logic [31:0]           dat_r, dat_s;
    logic [31:0]           resp_r, resp_s;
    logic [1:0]            cnt_r, cnt_s;
    logic [TW-1:0]         timer_r, timer_s;
    logic                  rx_pending_s, tx_idle_s;

    // Two-flop synchronisers for the toggles arriving from the SPI clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b0;
            rx_req_r  <= 1'b0;
            tx_meta_r <= 1'b0;
            tx_ack_r  <= 1'b0;
        end else begin
            rx_meta_r <= rx_handshake_req;
            rx_req_r  <= rx_meta_r;
            tx_meta_r <= tx_handshake_ack;
            tx_ack_r  <= tx_meta_r;
        end
    end

    assign rx_pending_s = rx_req_r ^ rx_ack_r;
    assign tx_idle_s    = (tx_req_r == tx_ack_r);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ack_r  <= 1'b0;
            tx_req_r  <= 1'b0;
            tx_data_r <= 8'h00;
            cyc_r     <= 1'b0;
            we_out_r  <= 1'b0;
            cmd_we_r  <= 1'b0;
            adr_r     <= '0;
            dat_r     <= 32'h0000_0000;
            resp_r    <= 32'h0000_0000;
            cnt_r     <= 2'd0;
            timer_r   <= '0;
        end else begin
            rx_ack_r  <= rx_ack_s;
            tx_req_r  <= tx_req_s;
            tx_data_r <= tx_data_s;
            cyc_r     <= cyc_s;
            we_out_r  <= we_out_s;
            cmd_we_r  <= cmd_we_s;
            adr_r     <= adr_s;
            dat_r     <= dat_s;
            resp_r    <= resp_s;
            cnt_r     <= cnt_s;
            timer_r   <= timer_s;
        end
    end

    // Command parsing, Wishbone cycle control and response streaming
    always_comb begin
        state_s   = state_r;
        rx_ack_s  = rx_ack_r;
        tx_req_s  = tx_req_r;
        tx_data_s = tx_data_r;
        cyc_s     = cyc_r;
        we_out_s  = we_out_r;
        cmd_we_s  = cmd_we_r;
        adr_s     = adr_r;
        dat_s     = dat_r;
        resp_s    = resp_r;
        cnt_s     = cnt_r;
        timer_s   = timer_r;
        case (state_r)
            ST_IDLE: begin
                if (rx_pending_s) begin
                    rx_ack_s = rx_req_r;
                    cmd_we_s = rx_handshake_data[7];
                    state_s  = ST_ADDR;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (rx_pending_s) begin
                    rx_ack_s = rx_req_r;
                    adr_s    = ADDR_WIDTH'(rx_handshake_data);
                    cnt_s    = 2'd0;
                    state_s  = cmd_we_r ? ST_WDATA : ST_WB;
                end else begin
                    state_s  = ST_ADDR;
                end
            end
            ST_WDATA: begin
                if (rx_pending_s) begin
                    rx_ack_s = rx_req_r;
                    dat_s    = {dat_r[23:0], rx_handshake_data};
                    cnt_s    = cnt_r + 2'd1;
                    state_s  = (cnt_r == 2'd3) ? ST_WB : ST_WDATA;
                end else begin
                    state_s  = ST_WDATA;
                end
            end
            ST_WB: begin
                // cyc_r low here marks the entry cycle; an ack is only honoured once the strobe is out
                if (!cyc_r) begin
                    cyc_s    = 1'b1;
                    we_out_s = cmd_we_r;
                    timer_s  = '0;
                end else if (wb_ack_i) begin
                    cyc_s    = 1'b0;
                    we_out_s = 1'b0;
                    cnt_s    = 2'd0;
                    resp_s   = wb_dat_i;
                    state_s  = cmd_we_r ? ST_IDLE : ST_RESP;
                end else if (timer_r == TW'(TIMEOUT - 1)) begin
                    cyc_s    = 1'b0;
                    we_out_s = 1'b0;
                    cnt_s    = 2'd0;
                    resp_s   = 32'hFFFF_FFFF;
                    state_s  = cmd_we_r ? ST_IDLE : ST_RESP;
                end else begin
                    timer_s  = timer_r + TW'(1);
                end
            end
            ST_RESP: begin
                if (tx_idle_s) begin
                    tx_data_s = resp_r[31:24];
                    tx_req_s  = ~tx_req_r;
                    resp_s    = {resp_r[23:0], 8'h00};
                    cnt_s     = cnt_r + 2'd1;
                    state_s   = (cnt_r == 2'd3) ? ST_IDLE : ST_RESP;
                end else begin
                    state_s   = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign rx_handshake_ack  = rx_ack_r;
    assign tx_handshake_req  = tx_req_r;
    assign tx_handshake_data = tx_data_r;
    assign wb_cyc_o          = cyc_r;
    assign wb_stb_o          = cyc_r;
    assign wb_we_o           = we_out_r;
    assign wb_adr_o          = adr_r;
    assign wb_dat_o          = dat_r;

endmodule

// File: tb/tb_wbm_spi_ctrl.sv
// Self-checking bench for wbm_spi_ctrl: emulates the SPI rx/tx stages and a Wishbone slave,
// and compares Wishbone cycles and returned bytes against a transaction-level model.
`timescale 1ns/1ps
module tb_wbm_spi_ctrl;
    localparam int AW  = 8;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tb_rx_req;
    logic [7:0]    tb_rx_data;
    logic          rx_ack;
    logic          tx_req;
    logic          tb_tx_ack;
    logic [7:0]    tx_data;
    logic          cyc, stb, we;
    logic [AW-1:0] adr;
    logic [31:0]   dat_o, dat_i;
    logic          wb_ack;

    always #5 clk = ~clk;

    wbm_spi_ctrl #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_handshake_req(tb_rx_req), .rx_handshake_data(tb_rx_data), .rx_handshake_ack(rx_ack),
        .tx_handshake_req(tx_req), .tx_handshake_ack(tb_tx_ack), .tx_handshake_data(tx_data),
        .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_adr_o(adr), .wb_dat_o(dat_o),
        .wb_dat_i(dat_i), .wb_ack_i(wb_ack)
    );

    typedef struct {
        logic        we;
        logic [7:0]  adr;
        logic [31:0] dat;
        int          len;
    } wb_exp_t;

    wb_exp_t     wb_exp_q[$];
    wb_exp_t     wb_log[$];
    logic [7:0]  tx_exp_q[$];
    logic [7:0]  tx_log[$];
    int          tx_count = 0;
    int          last_stb_cnt = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    int          ack_delay = 1;
    logic [31:0] slave_data = 32'h0;
    bit          stray_ack = 1'b0;
    bit          tx_hold = 1'b0;
    int          tx_delay = 3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] txl(input int i);
        if (i < tx_log.size()) return tx_log[i];
        return 8'hxx;
    endfunction

    // Model: one command -> one Wishbone cycle; reads return 4 bytes MSB first (all-ones on timeout)
    task automatic model_cmd(input logic we_b, input logic [7:0] a, input logic [31:0] wd,
                             input logic [31:0] rd, input int delay);
        wb_exp_t     e;
        logic [31:0] r;
        bit          acked;
        acked = (delay != 0) && (delay <= TMO);
        e.we = we_b; e.adr = a; e.dat = wd; e.len = acked ? delay : TMO;
        wb_exp_q.push_back(e);
        if (!we_b) begin
            r = acked ? rd : 32'hFFFF_FFFF;
            for (int i = 3; i >= 0; i--) tx_exp_q.push_back(r[8*i +: 8]);
        end
    endtask

    // Wishbone slave: acks after ack_delay strobe cycles (0 = never)
    initial begin
        int cnt;
        cnt = 0; wb_ack = 1'b0; dat_i = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (cyc && rst_n) begin
                cnt++;
                dat_i  = slave_data;
                wb_ack = (ack_delay != 0) && (cnt == ack_delay);
            end else begin
                cnt    = 0;
                dat_i  = 32'h0;
                wb_ack = stray_ack;
            end
        end
    end

    // SPI transmit stage: returns the ack toggle tx_delay cycles after a new offer
    initial begin
        int cnt;
        cnt = 0; tb_tx_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                cnt = 0; tb_tx_ack = 1'b0;
            end else if (tx_req != tb_tx_ack && !tx_hold) begin
                cnt++;
                if (cnt >= tx_delay) begin
                    tb_tx_ack = ~tb_tx_ack; cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Compare process
    initial begin
        bit      active;
        int      scnt;
        logic    prev_cyc, prev_txr;
        wb_exp_t cur, obs;
        active = 1'b0; scnt = 0; prev_cyc = 1'b0; prev_txr = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset_ctrl_outputs", {cyc, stb, we, rx_ack, tx_req}, 32'h0);
                chk("reset_data_outputs", {tx_data, adr, dat_o[15:0]}, 32'h0);
                active = 1'b0; prev_cyc = 1'b0; prev_txr = 1'b0;
            end else begin
                if (cyc && !prev_cyc) begin
                    if (wb_exp_q.size() == 0) begin
                        chk("wb_unexpected_cycle", 32'd1, 32'd0);
                    end else begin
                        cur = wb_exp_q.pop_front(); active = 1'b1; scnt = 0;
                        obs.we = we; obs.adr = adr; obs.dat = dat_o; obs.len = 0;
                        wb_log.push_back(obs);
                    end
                end
                if (cyc && active) begin
                    chk("wb_stb", stb, 1'b1);
                    chk("wb_we", we, cur.we);
                    chk("wb_adr", adr, cur.adr);
                    if (cur.we) chk("wb_dat_o", dat_o, cur.dat);
                    scnt++;
                end
                if (!cyc) chk("wb_idle_stb_we", {stb, we}, 2'b00);
                if (!cyc && prev_cyc && active) begin
                    last_stb_cnt = scnt;
                    if (cur.len != 0) chk("wb_stb_cycles", scnt, cur.len);
                    active = 1'b0;
                end
                if (tx_req != prev_txr) begin
                    chk("tx_offer_when_idle", tb_tx_ack, prev_txr);
                    if (tx_exp_q.size() == 0) chk("tx_unexpected_byte", 32'd1, 32'd0);
                    else chk("tx_data", tx_data, tx_exp_q.pop_front());
                    tx_log.push_back(tx_data);
                    tx_count++;
                end
                prev_cyc = cyc; prev_txr = tx_req;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int k;
        k = 0;
        while (rx_ack != tb_rx_req && k < 300) begin @(posedge clk); #1; k++; end
        if (rx_ack != tb_rx_req) chk("rx_consume_timeout", rx_ack, tb_rx_req);
        @(posedge clk); #1;
        tb_rx_data = b;
        tb_rx_req  = ~tb_rx_req;
    endtask

    task automatic wait_cyc(input logic v, input string name);
        int k;
        k = 0;
        while (cyc !== v && k < 200) begin @(posedge clk); #1; k++; end
        if (cyc !== v) chk(name, cyc, v);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((wb_exp_q.size() != 0 || tx_exp_q.size() != 0 || cyc || tx_req != tb_tx_ack) && k < 500) begin
            @(posedge clk); #1; k++;
        end
        chk("drain_timeout", (k < 500), 1'b1);
        wb_exp_q.delete(); tx_exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic [7:0] cmd, input logic [7:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int delay);
        slave_data = rd; ack_delay = delay;
        model_cmd(cmd[7], a, wd, rd, delay);
        send_byte(cmd);
        send_byte(a);
        if (cmd[7]) for (int i = 3; i >= 0; i--) send_byte(wd[8*i +: 8]);
        wait_idle();
    endtask

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int      n, base;
        logic    old;
        wb_exp_t e;
        rst_n = 1'b1; tb_rx_req = 1'b0; tb_rx_data = 8'h00;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_cyc_stb_we", {cyc, stb, we}, 3'b000);
        chk("reset_handshakes", {rx_ack, tx_req}, 2'b00);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Read 0x24 with rx sync latency and first-tx latency measured
        slave_data = 32'h1234_5678; ack_delay = 2;
        model_cmd(1'b0, 8'h24, 32'h0, 32'h1234_5678, 2);
        @(posedge clk); #1;
        old = rx_ack; tb_rx_data = 8'h00; tb_rx_req = ~tb_rx_req; n = 0;
        while (rx_ack == old && n < 10) begin @(posedge clk); #1; n++; end
        chk("rx_sync_latency", n, 3);
        send_byte(8'h24);
        wait_cyc(1'b1, "read_cyc_rise");
        wait_cyc(1'b0, "read_cyc_fall");
        old = tx_req; n = 0;
        while (tx_req == old && n < 10) begin @(posedge clk); #1; n++; end
        chk("read_first_tx_latency", n, 1);
        wait_idle();
        chk("read_byte0", txl(0), 8'h12);
        chk("read_byte1", txl(1), 8'h34);
        chk("read_byte2", txl(2), 8'h56);
        chk("read_byte3", txl(3), 8'h78);

        // Write 0xDEADBEEF to 0x10, cyc one clock after the last data byte is consumed
        base = tx_count; ack_delay = 2;
        model_cmd(1'b1, 8'h10, 32'hDEAD_BEEF, 32'h0, 2);
        send_byte(8'h80); send_byte(8'h10); send_byte(8'hDE);
        send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        old = rx_ack; n = 0;
        while (rx_ack == old && n < 10) begin @(posedge clk); #1; n++; end
        n = 0;
        while (!cyc && n < 10) begin @(posedge clk); #1; n++; end
        chk("write_cyc_latency", n, 1);
        wait_idle();
        chk("write_log_adr", (wb_log.size() > 0) ? wb_log[wb_log.size()-1].adr : 8'hxx, 8'h10);
        chk("write_log_dat", (wb_log.size() > 0) ? wb_log[wb_log.size()-1].dat : 32'hx, 32'hDEAD_BEEF);
        chk("write_no_tx", tx_count - base, 0);

        // Timeout read of 0x30: 4 strobe cycles then all-ones
        base = tx_count;
        run_cmd(8'h00, 8'h30, 32'h0, 32'h5555_5555, 0);
        chk("timeout_stb_cycles", last_stb_cnt, 4);
        chk("timeout_bytes", {txl(base), txl(base+1), txl(base+2), txl(base+3)}, 32'hFFFF_FFFF);

        // Ack on the same cycle as the timeout compare wins; cmd bits 6:0 ignored
        base = tx_count;
        run_cmd(8'h7F, 8'h31, 32'h0, 32'hCAFE_F00D, 4);
        chk("ackwins_bytes", {txl(base), txl(base+1), txl(base+2), txl(base+3)}, 32'hCAFE_F00D);

        // Stray ack while idle is ignored
        base = tx_count; stray_ack = 1'b1;
        repeat (5) @(posedge clk);
        #1 stray_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("stray_ack_no_cyc", cyc, 1'b0);
        chk("stray_ack_no_tx", tx_count - base, 0);

        // Backpressure: next command byte waits until RESP has offered all 4 bytes
        base = tx_count; tx_hold = 1'b1; slave_data = 32'hA1B2_C3D4; ack_delay = 1;
        model_cmd(1'b0, 8'h40, 32'h0, 32'hA1B2_C3D4, 1);
        model_cmd(1'b1, 8'h41, 32'h0102_0304, 32'h0, 1);
        send_byte(8'h00); send_byte(8'h40);
        n = 0;
        while (tx_count == base && n < 100) begin @(posedge clk); #1; n++; end
        send_byte(8'h80);
        old = rx_ack;
        repeat (20) @(posedge clk);
        #1;
        chk("bp_rx_ack_held", rx_ack, old);
        chk("bp_one_byte_offered", tx_count - base, 1);
        tx_hold = 1'b0;
        n = 0;
        while (rx_ack == old && n < 200) begin @(posedge clk); #1; n++; end
        chk("bp_consumed_after_resp", tx_count - base, 4);
        send_byte(8'h41); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h03); send_byte(8'h04);
        wait_idle();
        chk("bp_bytes", {txl(base), txl(base+1), txl(base+2), txl(base+3)}, 32'hA1B2_C3D4);

        // Asynchronous reset in the middle of a Wishbone cycle
        ack_delay = 0;
        e.we = 1'b0; e.adr = 8'h55; e.dat = 32'h0; e.len = 0;
        wb_exp_q.push_back(e);
        send_byte(8'h00); send_byte(8'h55);
        wait_cyc(1'b1, "rst_cyc_rise");
        #2 rst_n = 1'b0; tb_rx_req = 1'b0;
        #1;
        chk("rst_async_cyc", cyc, 1'b0);
        chk("rst_async_stb", stb, 1'b0);
        chk("rst_async_we", we, 1'b0);
        chk("rst_async_hs", {rx_ack, tx_req}, 2'b00);
        wb_exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        base = tx_count;
        run_cmd(8'h00, 8'h01, 32'h0, 32'h0BAD_F00D, 3);
        chk("post_reset_bytes", {txl(base), txl(base+1), txl(base+2), txl(base+3)}, 32'h0BAD_F00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
